// File: rtl/cu_pkg.sv
// Shared encodings for the core control unit: opcodes, bus/ALU codes, register-enable bit
// positions, the FSM state type, and the opcode-to-first-execute-state decoder.
package cu_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_ENDOP = 8'h01;
    localparam logic [7:0] OP_CLAC  = 8'h02;
    localparam logic [7:0] OP_LDIAC = 8'h03;
    localparam logic [7:0] OP_LDAC  = 8'h04;
    localparam logic [7:0] OP_STR   = 8'h05;
    localparam logic [7:0] OP_STIR  = 8'h06;
    localparam logic [7:0] OP_JUMP  = 8'h07;
    localparam logic [7:0] OP_JMPNZ = 8'h08;
    localparam logic [7:0] OP_JMPZ  = 8'h09;
    localparam logic [7:0] OP_MUL   = 8'h0A;
    localparam logic [7:0] OP_ADD   = 8'h0B;
    localparam logic [7:0] OP_SUB   = 8'h0C;
    localparam logic [7:0] OP_INCAC = 8'h0D;
    localparam logic [3:0] OP_MV_LO = 4'hF;

    localparam logic [3:0] BUS_NONE = 4'd0;
    localparam logic [3:0] BUS_PC   = 4'd1;
    localparam logic [3:0] BUS_IM   = 4'd2;
    localparam logic [3:0] BUS_DM   = 4'd3;
    localparam logic [3:0] BUS_R    = 4'd4;
    localparam logic [3:0] BUS_AC   = 4'd5;
    localparam logic [3:0] BUS_RL   = 4'd6;
    localparam logic [3:0] BUS_RP   = 4'd7;
    localparam logic [3:0] BUS_RQ   = 4'd8;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_CLR  = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;
    localparam logic [2:0] ALU_MUL  = 3'd4;
    localparam logic [2:0] ALU_INC  = 3'd5;

    // Bit positions within wrEnReg {AR,R,PC,IR,RL,RC,RP,RQ,R1,AC} and incReg {PC,RC,RP,RQ}
    localparam int WR_AR = 9;
    localparam int WR_R  = 8;
    localparam int WR_PC = 7;
    localparam int WR_IR = 6;
    localparam int WR_RL = 5;
    localparam int WR_RC = 4;
    localparam int WR_RP = 3;
    localparam int WR_RQ = 2;
    localparam int WR_R1 = 1;
    localparam int WR_AC = 0;
    localparam int INC_PC = 3;

    typedef enum logic [5:0] {
        S_IDLE, S_F1, S_F2, S_F3, S_NOP, S_END, S_DONE, S_CLAC,
        S_LDI1, S_LDI2, S_LDI3, S_LDI4, S_LDI5,
        S_LDA1, S_LDA2, S_LDA3,
        S_STR1, S_STR2, S_STR3,
        S_STI1, S_STI2, S_STI3, S_STI4, S_STI5,
        S_JMP1, S_JMP2, S_JMP3, S_SKIP,
        S_MUL, S_ADD, S_SUB, S_INC,
        S_MV_RL_AC, S_MV_RP_AC, S_MV_RQ_AC, S_MV_RC_AC, S_MV_R_AC, S_MV_R1_AC,
        S_MV_AC_RP, S_MV_AC_RQ, S_MV_AC_RL
    } state_t;

    // Conditional jumps resolve here, so the first execute state already knows taken/skip.
    function automatic state_t decode_op(input logic [7:0] op, input logic z,
                                         input state_t undef_st);
        state_t s;
        s = undef_st;
        if (op[3:0] == OP_MV_LO) begin
            case (op[7:4])
                4'd1: s = S_MV_RL_AC;
                4'd2: s = S_MV_RP_AC;
                4'd3: s = S_MV_RQ_AC;
                4'd4: s = S_MV_RC_AC;
                4'd5: s = S_MV_R_AC;
                4'd6: s = S_MV_R1_AC;
                4'd7: s = S_MV_AC_RP;
                4'd8: s = S_MV_AC_RQ;
                4'd9: s = S_MV_AC_RL;
                default: s = undef_st;
            endcase
        end else begin
            case (op)
                OP_NOP:   s = S_NOP;
                OP_ENDOP: s = S_END;
                OP_CLAC:  s = S_CLAC;
                OP_LDIAC: s = S_LDI1;
                OP_LDAC:  s = S_LDA1;
                OP_STR:   s = S_STR1;
                OP_STIR:  s = S_STI1;
                OP_JUMP:  s = S_JMP1;
                OP_JMPNZ: s = z ? S_SKIP : S_JMP1;
                OP_JMPZ:  s = z ? S_JMP1 : S_SKIP;
                OP_MUL:   s = S_MUL;
                OP_ADD:   s = S_ADD;
                OP_SUB:   s = S_SUB;
                OP_INCAC: s = S_INC;
                default:  s = undef_st;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Moore output table: maps the control-unit state to datapath strobes.
module control_unit_decode
    import cu_pkg::*;
(
    input  state_t      state_i,
    output logic [2:0]  alu_op,
    output logic [3:0]  inc_reg,
    output logic [9:0]  wr_en_reg,
    output logic [3:0]  bus_sel,
    output logic        dm_wr_en,
    output logic        z_wr_en,
    output logic        done,
    output logic        ready
);

    always_comb begin
        alu_op    = ALU_PASS;
        inc_reg   = '0;
        wr_en_reg = '0;
        bus_sel   = BUS_NONE;
        dm_wr_en  = 1'b0;
        z_wr_en   = 1'b0;
        done      = 1'b0;
        ready     = 1'b0;
        case (state_i)
            S_IDLE: ready = 1'b1;
            S_DONE: done = 1'b1;
            S_F1, S_LDI1, S_STI1, S_JMP1: begin
                bus_sel = BUS_PC;
                wr_en_reg[WR_AR] = 1'b1;
            end
            S_F3: begin
                bus_sel = BUS_IM;
                wr_en_reg[WR_IR] = 1'b1;
                inc_reg[INC_PC] = 1'b1;
            end
            S_LDI3, S_STI3: begin
                bus_sel = BUS_IM;
                wr_en_reg[WR_AR] = 1'b1;
                inc_reg[INC_PC] = 1'b1;
            end
            S_LDI5, S_LDA3: begin
                bus_sel = BUS_DM;
                wr_en_reg[WR_AC] = 1'b1;
            end
            S_LDA1, S_STR1: begin
                bus_sel = BUS_R;
                wr_en_reg[WR_AR] = 1'b1;
            end
            S_STR2, S_STI4: begin
                bus_sel = BUS_AC;
                dm_wr_en = 1'b1;
            end
            S_JMP3: begin
                bus_sel = BUS_IM;
                wr_en_reg[WR_PC] = 1'b1;
            end
            S_SKIP: inc_reg[INC_PC] = 1'b1;
            S_CLAC, S_MUL, S_ADD, S_SUB, S_INC: begin
                wr_en_reg[WR_AC] = 1'b1;
                z_wr_en = 1'b1;
                case (state_i)
                    S_CLAC:  alu_op = ALU_CLR;
                    S_MUL:   alu_op = ALU_MUL;
                    S_ADD:   alu_op = ALU_ADD;
                    S_SUB:   alu_op = ALU_SUB;
                    default: alu_op = ALU_INC;
                endcase
            end
            S_MV_RL_AC: begin bus_sel = BUS_AC; wr_en_reg[WR_RL] = 1'b1; end
            S_MV_RP_AC: begin bus_sel = BUS_AC; wr_en_reg[WR_RP] = 1'b1; end
            S_MV_RQ_AC: begin bus_sel = BUS_AC; wr_en_reg[WR_RQ] = 1'b1; end
            S_MV_RC_AC: begin bus_sel = BUS_AC; wr_en_reg[WR_RC] = 1'b1; end
            S_MV_R_AC:  begin bus_sel = BUS_AC; wr_en_reg[WR_R]  = 1'b1; end
            S_MV_R1_AC: begin bus_sel = BUS_AC; wr_en_reg[WR_R1] = 1'b1; end
            S_MV_AC_RP: begin bus_sel = BUS_RP; wr_en_reg[WR_AC] = 1'b1; end
            S_MV_AC_RQ: begin bus_sel = BUS_RQ; wr_en_reg[WR_AC] = 1'b1; end
            S_MV_AC_RL: begin bus_sel = BUS_RL; wr_en_reg[WR_AC] = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for one core; holds the state register, outputs come from
// control_unit_decode. Define CU_ILLEGAL_HALT_EN to halt (DONE) on undefined opcodes.
module control_unit
    import cu_pkg::*;
#(
    parameter int INS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 Zout,
    input  logic [INS_WIDTH-1:0] ins,
    output logic [2:0]           aluOp,
    output logic [3:0]           incReg,
    output logic [9:0]           wrEnReg,
    output logic [3:0]           busSel,
    output logic                 DataMemWrEn,
    output logic                 ZWrEn,
    output logic                 done,
    output logic                 ready
);

`ifdef CU_ILLEGAL_HALT_EN
    localparam state_t UNDEF_ST = S_END;
`else
    localparam state_t UNDEF_ST = S_NOP;
`endif

    state_t     state_q, state_d;
    logic [7:0] op;

    assign op = ins[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Any execute state not listed is the last of its instruction and returns to fetch.
    always_comb begin
        state_d = S_F1;
        case (state_q)
            S_IDLE: state_d = start ? S_F1 : S_IDLE;
            S_DONE: state_d = start ? S_DONE : S_IDLE;
            S_F1:   state_d = S_F2;
            S_F2:   state_d = S_F3;
            S_F3:   state_d = decode_op(op, Zout, UNDEF_ST);
            S_END:  state_d = S_DONE;
            S_LDI1: state_d = S_LDI2;
            S_LDI2: state_d = S_LDI3;
            S_LDI3: state_d = S_LDI4;
            S_LDI4: state_d = S_LDI5;
            S_LDA1: state_d = S_LDA2;
            S_LDA2: state_d = S_LDA3;
            S_STR1: state_d = S_STR2;
            S_STR2: state_d = S_STR3;
            S_STI1: state_d = S_STI2;
            S_STI2: state_d = S_STI3;
            S_STI3: state_d = S_STI4;
            S_STI4: state_d = S_STI5;
            S_JMP1: state_d = S_JMP2;
            S_JMP2: state_d = S_JMP3;
            default: state_d = S_F1;
        endcase
    end

    control_unit_decode u_decode (
        .state_i   (state_q),
        .alu_op    (aluOp),
        .inc_reg   (incReg),
        .wr_en_reg (wrEnReg),
        .bus_sel   (busSel),
        .dm_wr_en  (DataMemWrEn),
        .z_wr_en   (ZWrEn),
        .done      (done),
        .ready     (ready)
    );

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected outputs are queued by the stimulus
// and compared by an independent monitor on the falling edge.
module tb_control_unit;

    typedef struct packed {
        logic       ready;
        logic       done;
        logic [3:0] bus;
        logic [9:0] wr;
        logic [3:0] inc;
        logic [2:0] alu;
        logic       dmw;
        logic       zw;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       Zout = 1'b0;
    logic [7:0] ins = 8'h00;
    logic [2:0] aluOp;
    logic [3:0] incReg;
    logic [9:0] wrEnReg;
    logic [3:0] busSel;
    logic       DataMemWrEn, ZWrEn, done, ready;

    exp_t  exp_q[$];
    string nm_q[$];
    int    checks = 0;
    int    failures = 0;

    control_unit #(.INS_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .Zout(Zout), .ins(ins),
        .aluOp(aluOp), .incReg(incReg), .wrEnReg(wrEnReg), .busSel(busSel),
        .DataMemWrEn(DataMemWrEn), .ZWrEn(ZWrEn), .done(done), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic rdy, input logic dn, input logic [3:0] bus,
                                input logic [9:0] wr, input logic [3:0] inc,
                                input logic [2:0] alu, input logic dmw, input logic zw);
        exp_t e;
        e = '{rdy, dn, bus, wr, inc, alu, dmw, zw};
        return e;
    endfunction

    exp_t IDLE_E, DONE_E, ZERO_E, F1_E, F3_E, PCAR_E, IMAR_E;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e, a;
            string n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            a = '{ready, done, busSel, wrEnReg, incReg, aluOp, DataMemWrEn, ZWrEn};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got rdy=%b done=%b bus=%0d wr=%h inc=%h alu=%0d dmw=%b zw=%b, want rdy=%b done=%b bus=%0d wr=%h inc=%h alu=%0d dmw=%b zw=%b",
                         n, a.ready, a.done, a.bus, a.wr, a.inc, a.alu, a.dmw, a.zw,
                         e.ready, e.done, e.bus, e.wr, e.inc, e.alu, e.dmw, e.zw);
            end
        end
    end

    task automatic cyc(input exp_t e, input string n);
        exp_q.push_back(e);
        nm_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] op, input logic z, input string n);
        ins  = op;
        Zout = z;
        cyc(F1_E, {n, "_f1"});
        cyc(ZERO_E, {n, "_f2"});
        cyc(F3_E, {n, "_f3"});
    endtask

    initial begin
        IDLE_E = mk(1, 0, 0, 10'h000, 4'h0, 0, 0, 0);
        DONE_E = mk(0, 1, 0, 10'h000, 4'h0, 0, 0, 0);
        ZERO_E = mk(0, 0, 0, 10'h000, 4'h0, 0, 0, 0);
        F1_E   = mk(0, 0, 1, 10'h200, 4'h0, 0, 0, 0);
        F3_E   = mk(0, 0, 2, 10'h040, 4'h8, 0, 0, 0);
        PCAR_E = mk(0, 0, 1, 10'h200, 4'h0, 0, 0, 0);
        IMAR_E = mk(0, 0, 2, 10'h200, 4'h8, 0, 0, 0);

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) cyc(IDLE_E, "reset_idle");

        start = 1'b1;
        cyc(IDLE_E, "idle_start");
        start = 1'b0;

        fetch(8'd0, 0, "nop");
        cyc(ZERO_E, "nop_x1");

        fetch(8'd3, 0, "ldiac");
        cyc(PCAR_E, "ldiac_x1");
        cyc(ZERO_E, "ldiac_x2");
        cyc(IMAR_E, "ldiac_x3");
        cyc(ZERO_E, "ldiac_x4");
        cyc(mk(0, 0, 3, 10'h001, 4'h0, 0, 0, 0), "ldiac_x5");

        fetch(8'd9, 1, "jmpz_t");
        cyc(PCAR_E, "jmpz_t_x1");
        cyc(ZERO_E, "jmpz_t_x2");
        cyc(mk(0, 0, 2, 10'h080, 4'h0, 0, 0, 0), "jmpz_t_x3");

        fetch(8'd9, 0, "jmpz_n");
        cyc(mk(0, 0, 0, 10'h000, 4'h8, 0, 0, 0), "jmpz_n_x1");

        fetch(8'd8, 0, "jmpnz_t");
        cyc(PCAR_E, "jmpnz_t_x1");
        cyc(ZERO_E, "jmpnz_t_x2");
        cyc(mk(0, 0, 2, 10'h080, 4'h0, 0, 0, 0), "jmpnz_t_x3");

        fetch(8'd11, 0, "add");
        cyc(mk(0, 0, 0, 10'h001, 4'h0, 2, 0, 1), "add_x1");

        fetch(8'h9F, 0, "mv_ac_rl");
        cyc(mk(0, 0, 6, 10'h001, 4'h0, 0, 0, 0), "mv_ac_rl_x1");

        fetch(8'h1F, 0, "mv_rl_ac");
        cyc(mk(0, 0, 5, 10'h020, 4'h0, 0, 0, 0), "mv_rl_ac_x1");

        fetch(8'd5, 0, "str");
        cyc(mk(0, 0, 4, 10'h200, 4'h0, 0, 0, 0), "str_x1");
        cyc(mk(0, 0, 5, 10'h000, 4'h0, 0, 1, 0), "str_x2");
        cyc(ZERO_E, "str_x3");

        fetch(8'd2, 0, "clac");
        cyc(mk(0, 0, 0, 10'h001, 4'h0, 1, 0, 1), "clac_x1");

        fetch(8'hEE, 0, "undef");
        cyc(ZERO_E, "undef_x1");

        cyc(F1_E, "rstmid_f1");
        rst = 1'b1;
        cyc(IDLE_E, "rst_mid");
        rst = 1'b0;
        cyc(IDLE_E, "rst_mid_idle");

        start = 1'b1;
        cyc(IDLE_E, "end_start");
        fetch(8'd1, 0, "endop");
        cyc(ZERO_E, "endop_x1");
        cyc(DONE_E, "done_hold1");
        cyc(DONE_E, "done_hold2");
        start = 1'b0;
        cyc(DONE_E, "done_release");
        cyc(IDLE_E, "back_idle");

        begin : drain
            int n;
            n = 0;
            while (exp_q.size() > 0 && n < 10) begin
                @(posedge clk);
                n++;
            end
            if (exp_q.size() > 0) begin
                failures++;
                $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            end
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
